// File: rtl/hilo_muldiv_unit_pkg.sv
// hilo_muldiv_unit_pkg
//   Shared definitions for the HI/LO multiply/divide unit: FSM encoding,
//   command-pair bit indices, default width and the divide-by-zero quotient.
package hilo_muldiv_unit_pkg;

    localparam int DEF_WIDTH = 32;

    // Bit positions inside the MULT/DIV pairs.
    localparam int UNSIGNED_BIT = 1;
    localparam int SIGNED_BIT   = 0;

    // Bit positions inside the MTHL/MFHL pairs.
    localparam int HI_BIT = 1;
    localparam int LO_BIT = 0;

    // Quotient reported for a zero divisor (all ones). Held wide so any
    // WIDTH up to 64 can slice it.
    localparam logic [63:0] DIV0_QUOT = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// hilo_muldiv_unit_if
//   EX-stage command/result bundle between the pipeline and the HI/LO unit.
//   master : pipeline side (drives decoded commands and operands)
//   slave  : HI/LO unit side (returns read data, stall and HI/LO)
interface hilo_muldiv_unit_if
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             ex_valid;
    logic             cancel;
    logic [1:0]       MULT;        // [1]=multu, [0]=mult
    logic [1:0]       DIV;         // [1]=divu,  [0]=div
    logic [1:0]       MTHL;        // [1]=mthi,  [0]=mtlo
    logic [1:0]       MFHL;        // [1]=mfhi,  [0]=mflo
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] hilo_rdata;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output ex_valid, cancel, MULT, DIV, MTHL, MFHL, src_a, src_b,
        input  hilo_rdata, stall, hi, lo
    );

    modport slave (
        input  ex_valid, cancel, MULT, DIV, MTHL, MFHL, src_a, src_b,
        output hilo_rdata, stall, hi, lo
    );
endinterface

// File: rtl/hilo_muldiv_unit_div_iter_core.sv
// hilo_muldiv_unit_div_iter_core
//   Unsigned restoring divider, one quotient bit per step, WIDTH steps.
//   Ports:
//     clk, resetn        clock, async active-low reset
//     start              load magnitudes, clear counter
//     step               perform one shift/subtract iteration
//     dividend, divisor  unsigned magnitudes loaded on start
//     quot, rem          current quotient / remainder registers
//     done               high on the step that produces the last bit
module hilo_muldiv_unit_div_iter_core
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quot_q;   // shifts dividend out, quotient bits in
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             take;

    // Partial remainder is always < divisor, so the shifted value needs only
    // one extra bit; when the subtraction is taken its result fits in WIDTH.
    assign rem_sh = {rem_q, quot_q[WIDTH-1]};
    assign take   = rem_sh >= {1'b0, dvs_q};
    assign diff   = rem_sh[WIDTH-1:0] - dvs_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
        end else if (start) begin
            rem_q  <= '0;
            quot_q <= dividend;
            dvs_q  <= divisor;
            cnt_q  <= '0;
        end else if (step) begin
            rem_q  <= take ? diff : rem_sh[WIDTH-1:0];
            quot_q <= {quot_q[WIDTH-2:0], take};
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    assign done = step & (cnt_q == CW'(WIDTH - 1));
    assign quot = quot_q;
    assign rem  = rem_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
//   Execute-stage HI/LO unit: single-cycle mult/multu, iterative div/divu
//   (WIDTH BUSY cycles + one FIX cycle), mthi/mtlo writes and a
//   combinational mfhi/mflo read port.
//   Ports:
//     clk, resetn   pipeline clock, async active-low reset
//     bus (slave)   ex_valid/cancel, MULT/DIV/MTHL/MFHL command pairs,
//                   src_a/src_b operands; returns hilo_rdata, stall, hi, lo
module hilo_muldiv_unit
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter logic [WIDTH-1:0] HILO_RST = '0
) (
    input  logic               clk,
    input  logic               resetn,
    hilo_muldiv_unit_if.slave  bus
);
    state_e state_q, state_d;

    logic [WIDTH-1:0] hi_q, lo_q;
    logic             q_neg_q, r_neg_q, dz_q;

    logic             cmd_ok, div_go, div_sgn, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             core_step, core_done;
    logic [WIDTH-1:0] core_quot, core_rem, q_fix, r_fix;
    logic             mul_sgn;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic             stall, fix_wr;

    assign cmd_ok  = bus.ex_valid & ~bus.cancel;
    assign div_go  = (state_q == ST_IDLE) & cmd_ok & (|bus.DIV);

    // Operand magnitudes; signed only for div.
    assign div_sgn = bus.DIV[SIGNED_BIT];
    assign a_neg   = div_sgn & bus.src_a[WIDTH-1];
    assign b_neg   = div_sgn & bus.src_b[WIDTH-1];
    assign a_mag   = a_neg ? -bus.src_a : bus.src_a;
    assign b_mag   = b_neg ? -bus.src_b : bus.src_b;

    assign core_step = (state_q == ST_BUSY) & ~bus.cancel;

    hilo_muldiv_unit_div_iter_core #(.WIDTH(WIDTH)) u_div_core (
        .clk      (clk),
        .resetn   (resetn),
        .start    (div_go),
        .step     (core_step),
        .dividend (a_mag),
        .divisor  (b_mag),
        .quot     (core_quot),
        .rem      (core_rem),
        .done     (core_done)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
        end else if (div_go) begin
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
            dz_q    <= ~(|bus.src_b);
        end
    end

    // With a zero divisor the core leaves rem = |src_a|; restoring the
    // dividend sign yields the original src_a, so only LO needs overriding.
    assign q_fix = dz_q    ? DIV0_QUOT[WIDTH-1:0]
                 : q_neg_q ? -core_quot : core_quot;
    assign r_fix = r_neg_q ? -core_rem : core_rem;

    // Sign- or zero-extend to 2*WIDTH; the low 2*WIDTH bits of the product
    // are correct for both signed and unsigned operands.
    assign mul_sgn = bus.MULT[SIGNED_BIT];
    assign a_ext   = {{WIDTH{mul_sgn & bus.src_a[WIDTH-1]}}, bus.src_a};
    assign b_ext   = {{WIDTH{mul_sgn & bus.src_b[WIDTH-1]}}, bus.src_b};
    assign prod    = a_ext * b_ext;

    // FSM: state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (div_go) state_d = ST_BUSY;
            ST_BUSY: begin
                if (bus.cancel)     state_d = ST_IDLE;
                else if (core_done) state_d = ST_FIX;
            end
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs. Issue-cycle stall is combinational so the divide holds
    // in EX from its first cycle; FIX releases the pipeline.
    always_comb begin
        stall  = 1'b0;
        fix_wr = 1'b0;
        case (state_q)
            ST_IDLE: stall  = div_go;
            ST_BUSY: stall  = ~bus.cancel;
            ST_FIX:  fix_wr = ~bus.cancel;
            default: ;
        endcase
    end

    // HI/LO registers. DIV > MULT > MTHL when several bits are set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q <= HILO_RST;
            lo_q <= HILO_RST;
        end else if (fix_wr) begin
            lo_q <= q_fix;
            hi_q <= r_fix;
        end else if ((state_q == ST_IDLE) && cmd_ok && !(|bus.DIV)) begin
            if (|bus.MULT) begin
                {hi_q, lo_q} <= prod;
            end else begin
                if (bus.MTHL[HI_BIT]) hi_q <= bus.src_a;
                if (bus.MTHL[LO_BIT]) lo_q <= bus.src_a;
            end
        end
    end

    assign bus.hilo_rdata = bus.MFHL[HI_BIT] ? hi_q
                          : bus.MFHL[LO_BIT] ? lo_q : '0;
    assign bus.stall = stall;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Execute-stage HI/LO unit, directly downstream of the decode-stage control unit.
- Consumes the decoded MULT, DIV, MTHL and MFHL command pairs together with the two register operands.
- Owns the architectural HI/LO registers: single-cycle multiply, iterative 32-cycle radix-2 divide, and combinational HI/LO read for mfhi/mflo.
- Drives a stall to the pipeline while a divide is in flight.

Parameters:
- WIDTH, 32, operand/HI/LO width; divide iteration count equals WIDTH.
- HILO_RST, 0, reset value of HI and LO.

Ports:
- clk  in  1  pipeline clock.
- resetn  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX stage holds a valid instruction.
- cancel  in  1  exception/eret flush of EX; suppresses HI/LO writes and aborts a divide.
- MULT  in  2  [1]=multu, [0]=mult.
- DIV  in  2  [1]=divu, [0]=div.
- MTHL  in  2  [1]=mthi, [0]=mtlo.
- MFHL  in  2  [1]=mfhi, [0]=mflo.
- src_a  in  WIDTH  rs value (dividend, multiplicand, mthi/mtlo data).
- src_b  in  WIDTH  rt value (divisor, multiplier).
- hilo_rdata  out  WIDTH  HI if MFHL[1], LO if MFHL[0], else 0.
- stall  out  1  hold IF/ID/EX.
- hi  out  WIDTH  current HI.
- lo  out  WIDTH  current LO.

Behaviour:
- Reset (resetn=0, asynchronous): HI=LO=HILO_RST, state=IDLE, counter=0, stall=0, internal divider registers cleared.
- Effective command: cmd_ok = ex_valid & ~cancel. At most one of MULT/DIV/MTHL/MFHL bits is set (guaranteed by decode); if several are set, priority is DIV > MULT > MTHL.
- mult/multu (IDLE): {HI,LO} <= signed/unsigned 64-bit product at the end of the same cycle; no stall.
- mthi/mtlo (IDLE): HI or LO <= src_a at the end of the cycle.
- mfhi/mflo: combinational read of the current registers. A write in cycle N is visible to a read in cycle N+1; no bypass within the same cycle.
- FSM states: IDLE, BUSY, FIX.
- IDLE -> BUSY when cmd_ok & |DIV:
  - latch |src_a|, |src_b| (absolute values only when DIV[0]);
  - latch the quotient sign (sa^sb) and remainder sign (sa);
  - clear the counter;
  - stall=1 combinationally in this issue cycle.
- BUSY:
  - one restoring-division step per cycle;
  - counter increments 0..WIDTH-1;
  - stall=1;
  - on counter==WIDTH-1, go to FIX.
- FIX:
  - apply signs to the result;
  - LO <= quotient, HI <= remainder at the end of the cycle;
  - stall=0, so the divide leaves EX this cycle;
  - next state IDLE.
- Total stall cycles per divide = WIDTH+1 (33); HI/LO are written in cycle 34.
- Divide by zero: LO=32'hFFFF_FFFF, HI=dividend (original signed src_a); same latency.
- Signed 0x80000000 / -1: LO=0x80000000, HI=0. This falls out of the magnitude algorithm and needs no special case.
- Commands presented while in BUSY or FIX are ignored; the pipeline is frozen by stall.
- cancel while in BUSY or FIX: go to IDLE next cycle, stall=0 immediately, HI/LO unchanged.
- cancel in the issue cycle: the divide does not start and stall=0.
- Reset mid-divide: immediately IDLE with HI/LO reset; the partial result is lost.
- All outputs are registered or derived from registers/state, except hilo_rdata and the issue-cycle stall, which are combinational.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE/BUSY/FIX);
  - bit-index constants for the MULT/DIV/MTHL/MFHL pairs (UNSIGNED_BIT=1, SIGNED_BIT=0);
  - WIDTH default;
  - divide-by-zero quotient constant.
- One natural sub-module: div_iter_core. It holds:
  - the magnitude registers;
  - the per-cycle shift/subtract datapath;
  - the iteration counter, with a done pulse.
- hilo_muldiv_unit keeps the FSM, sign handling, multiplier, HI/LO registers and read mux.

Test Plan:
- Reset then mult: resetn low -> hi=lo=0, stall=0. mult src_a=0xFFFFFFFF (-1), src_b=2 -> next cycle hi=0xFFFFFFFF, lo=0xFFFFFFFE. multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- Signed divide: div src_a=-7 (0xFFFFFFF9), src_b=2 -> stall high for exactly 33 cycles; after the FIX cycle lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu 100/7 -> lo=14, hi=2.
- Divide by zero and overflow case: divu 0x1234/0 -> lo=0xFFFFFFFF, hi=0x1234 after 34 cycles. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Move/read ordering: mthi 0xA5A5A5A5, then mflo in the next cycle -> hilo_rdata=old LO. Then mfhi -> 0xA5A5A5A5. mtlo with cancel=1 -> lo unchanged.
- Cancel mid-divide: div 100/3 issued, cancel asserted in BUSY cycle 10 -> stall=0 that cycle, state IDLE next cycle, hi/lo keep their prior values. A fresh divu 9/4 afterwards -> lo=2, hi=1.
- Async reset mid-divide: resetn low in BUSY cycle 5, released between clock edges -> hi=lo=0, stall=0 at once. No HI/LO write occurs later.
